// File: rtl/edp_slice_param.sv
// One WIDTH-bit slice of the execution data path: AR/ARX/BR/BRX/MQ registers,
// A/B-select adder with slice generate/propagate, parity-protected fast
// memory with a sticky parity-error flag, and the EBUS/diagnostic driver.
// Slice bit 0 is the most significant bit; it lives at vector index WIDTH-1.
module edp_slice_param #(
    parameter int WIDTH     = 6,
    parameter int FM_BLOCKS = 8,
    parameter int FM_ACS    = 16
) (
    input  logic                         clk_edp_h,
    input  logic                         reset_h,
    input  logic [WIDTH-1:0]             cache_data_h,
    input  logic [WIDTH-1:0]             sh_h,
    input  logic [WIDTH-1:0]             armm_h,
    input  logic [WIDTH-1:0]             vma_held_or_pc_h,
    input  logic                         ad_cry_in_h,
    input  logic                         shift_in_lsb_h,
    input  logic                         cram_ad_boole_h,
    input  logic [1:0]                   cram_ad_sel_h,
    input  logic [1:0]                   cram_ada_sel_h,
    input  logic                         cram_ada_dis_h,
    input  logic [1:0]                   cram_adb_sel_h,
    input  logic [2:0]                   ctl_arl_sel_h,
    input  logic                         ctl_ar_load_h,
    input  logic                         ctl_ar_clr_h,
    input  logic [1:0]                   ctl_arxl_sel_h,
    input  logic                         ctl_arx_load_h,
    input  logic                         cram_br_load_h,
    input  logic                         cram_brx_load_h,
    input  logic [1:0]                   ctl_mq_sel_h,
    input  logic                         ctl_mqm_en_h,
    input  logic [$clog2(FM_BLOCKS)-1:0] apr_fm_block_h,
    input  logic [$clog2(FM_ACS)-1:0]    apr_fm_adr_h,
    input  logic                         con_fm_write_h,
    input  logic                         fm_check_h,
    input  logic                         fm_parity_clr_h,
    input  logic                         ctl_ad_to_ebus_h,
    input  logic                         diag_read_h,
    input  logic [2:0]                   diag_sel_h,
    output logic [WIDTH-1:0]             ar_h,
    output logic [WIDTH-1:0]             arx_h,
    output logic [WIDTH-1:0]             br_h,
    output logic [WIDTH-1:0]             brx_h,
    output logic [WIDTH-1:0]             mq_h,
    output logic [WIDTH-1:0]             ad_h,
    output logic                         ad_cry_out_h,
    output logic                         ad_cg_h,
    output logic                         ad_cp_h,
    output logic                         ad_eq0_l,
    output logic [WIDTH-1:0]             fm_h,
    output logic [WIDTH-1:0]             ebus_d_h,
    output logic                         edp_fm_parity_h,
    output logic                         fm_parity_err_h
);

    localparam int FM_DEPTH = FM_BLOCKS * FM_ACS;
    localparam int IW       = $clog2(FM_DEPTH);

    logic [WIDTH-1:0] ar_reg, ar_next;
    logic [WIDTH-1:0] arx_reg, arx_next;
    logic [WIDTH-1:0] br_reg, br_next;
    logic [WIDTH-1:0] brx_reg, brx_next;
    logic [WIDTH-1:0] mq_reg, mq_next;
    logic             perr_reg, perr_next;

    logic [WIDTH-1:0] a_op, b_op, b_term, ad;
    logic [WIDTH:0]   arith_sum;
    logic             ad_cry;

    // Fast memory word: {odd parity bit, data}
    logic [WIDTH:0]   fm_mem [FM_DEPTH];
    logic [IW-1:0]    fm_idx;
    logic [WIDTH:0]   fm_rd;

    // Per-bit generate/propagate and the running group terms, LSB upward
    logic [WIDTH-1:0] bit_g, bit_p;
    logic [WIDTH:0]   grp_g, grp_p;

    assign fm_idx = IW'(apr_fm_block_h) * IW'(FM_ACS) + IW'(apr_fm_adr_h);
    assign fm_rd  = fm_mem[fm_idx];

    // Operand selection for the adder
    always_comb begin
        a_op = '0;
        b_op = '0;
        if (!cram_ada_dis_h) begin
            case (cram_ada_sel_h)
                2'd0: a_op = ar_reg;
                2'd1: a_op = arx_reg;
                2'd2: a_op = mq_reg;
                2'd3: a_op = vma_held_or_pc_h;
            endcase
        end
        case (cram_adb_sel_h)
            2'd0: b_op = fm_rd[WIDTH-1:0];
            2'd1: b_op = br_reg;
            2'd2: b_op = brx_reg;
            2'd3: b_op = ar_reg;
        endcase
    end

    // Second addend for the arithmetic functions and the resulting AD value
    always_comb begin
        b_term = b_op;
        case (cram_ad_sel_h)
            2'd0: b_term = b_op;
            2'd1: b_term = ~b_op;
            2'd2: b_term = a_op;
            2'd3: b_term = '0;
        endcase
        arith_sum = {1'b0, a_op} + {1'b0, b_term} + {{WIDTH{1'b0}}, ad_cry_in_h};
        ad        = arith_sum[WIDTH-1:0];
        ad_cry    = arith_sum[WIDTH];
        if (cram_ad_boole_h) begin
            ad_cry = 1'b0;
            case (cram_ad_sel_h)
                2'd0: ad = a_op & b_op;
                2'd1: ad = a_op | b_op;
                2'd2: ad = a_op ^ b_op;
                2'd3: ad = ~a_op;
            endcase
        end
    end

    // Slice lookahead: group generate is the carry out with no carry in,
    // group propagate is the AND of XOR-propagates (exclusive of generate).
    assign grp_g[0] = 1'b0;
    assign grp_p[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lookahead
            assign bit_g[gi]    = a_op[gi] & b_term[gi];
            assign bit_p[gi]    = a_op[gi] ^ b_term[gi];
            assign grp_g[gi+1]  = bit_g[gi] | (bit_p[gi] & grp_g[gi]);
            assign grp_p[gi+1]  = bit_p[gi] & grp_p[gi];
        end
    endgenerate

    assign ad_h         = ad;
    assign ad_cry_out_h = ad_cry;
    assign ad_cg_h      = cram_ad_boole_h ? 1'b0 : grp_g[WIDTH];
    assign ad_cp_h      = cram_ad_boole_h ? 1'b0 : grp_p[WIDTH];
    assign ad_eq0_l     = |ad;

    // Next-state selection for the data registers and the parity flag
    always_comb begin
        ar_next   = ar_reg;
        arx_next  = arx_reg;
        br_next   = br_reg;
        brx_next  = brx_reg;
        mq_next   = mq_reg;
        perr_next = perr_reg;

        if (ctl_ar_clr_h) begin
            ar_next = '0;
        end else if (ctl_ar_load_h) begin
            case (ctl_arl_sel_h)
                3'd0: ar_next = armm_h;
                3'd1: ar_next = cache_data_h;
                3'd2: ar_next = ad;
                3'd3: ar_next = sh_h;
                3'd4: ar_next = {ad[WIDTH-2:0], shift_in_lsb_h};
                3'd5: ar_next = {ad_cry, ad[WIDTH-1:1]};
                3'd6: ar_next = fm_rd[WIDTH-1:0];
                3'd7: ar_next = '0;
            endcase
        end

        if (ctl_arx_load_h) begin
            case (ctl_arxl_sel_h)
                2'd0: arx_next = cache_data_h;
                2'd1: arx_next = ad;
                2'd2: arx_next = ar_reg;
                2'd3: arx_next = mq_reg;
            endcase
        end

        if (cram_br_load_h)  br_next  = ar_reg;
        if (cram_brx_load_h) brx_next = arx_reg;

        if (ctl_mqm_en_h) begin
            case (ctl_mq_sel_h)
                2'd0: mq_next = mq_reg;
                2'd1: mq_next = {mq_reg[WIDTH-2:0], shift_in_lsb_h};
                2'd2: mq_next = {ad[0], mq_reg[WIDTH-1:1]};
                2'd3: mq_next = ad;
            endcase
        end

        // A word whose data and parity XOR to 0 fails odd parity; a new error
        // wins over a simultaneous clear.
        perr_next = (fm_check_h & ~(^fm_rd)) | (perr_reg & ~fm_parity_clr_h);
    end

    // Register state with asynchronous clear
    always_ff @(posedge clk_edp_h or posedge reset_h) begin
        if (reset_h) begin
            ar_reg   <= '0;
            arx_reg  <= '0;
            br_reg   <= '0;
            brx_reg  <= '0;
            mq_reg   <= '0;
            perr_reg <= 1'b0;
        end else begin
            ar_reg   <= ar_next;
            arx_reg  <= arx_next;
            br_reg   <= br_next;
            brx_reg  <= brx_next;
            mq_reg   <= mq_next;
            perr_reg <= perr_next;
        end
    end

    // Fast-memory write of the current AR with odd parity; contents never reset
    always_ff @(posedge clk_edp_h) begin
        if (con_fm_write_h) begin
            fm_mem[fm_idx] <= {~(^ar_reg), ar_reg};
        end
    end

    // EBUS driver: diagnostic read first, then AD, otherwise idle low
    always_comb begin
        ebus_d_h = '0;
        if (diag_read_h) begin
            case (diag_sel_h)
                3'd0: ebus_d_h = ar_reg;
                3'd1: ebus_d_h = arx_reg;
                3'd2: ebus_d_h = br_reg;
                3'd3: ebus_d_h = brx_reg;
                3'd4: ebus_d_h = mq_reg;
                3'd5: ebus_d_h = fm_rd[WIDTH-1:0];
                3'd6: ebus_d_h = ad;
                3'd7: ebus_d_h = '0;
            endcase
        end else if (ctl_ad_to_ebus_h) begin
            ebus_d_h = ad;
        end
    end

    assign ar_h            = ar_reg;
    assign arx_h           = arx_reg;
    assign br_h            = br_reg;
    assign brx_h           = brx_reg;
    assign mq_h            = mq_reg;
    assign fm_h            = fm_rd[WIDTH-1:0];
    assign edp_fm_parity_h = fm_rd[WIDTH];
    assign fm_parity_err_h = perr_reg;

endmodule

// File: tb/tb_edp_slice_param.sv
// Bench for edp_slice_param: directed scenarios plus randomized cycles, all
// checked against an integer model of the slice kept in this file.
module tb_edp_slice_param;

    localparam int W  = 6;
    localparam int NB = 8;
    localparam int NA = 16;
    localparam int ND = NB * NA;
    localparam int M  = (1 << W) - 1;

    logic         clk_edp_h = 1'b0;
    logic         reset_h = 1'b1;
    logic [W-1:0] cache_data_h, sh_h, armm_h, vma_held_or_pc_h;
    logic         ad_cry_in_h, shift_in_lsb_h, cram_ad_boole_h;
    logic [1:0]   cram_ad_sel_h, cram_ada_sel_h, cram_adb_sel_h;
    logic         cram_ada_dis_h;
    logic [2:0]   ctl_arl_sel_h;
    logic         ctl_ar_load_h, ctl_ar_clr_h;
    logic [1:0]   ctl_arxl_sel_h;
    logic         ctl_arx_load_h, cram_br_load_h, cram_brx_load_h;
    logic [1:0]   ctl_mq_sel_h;
    logic         ctl_mqm_en_h;
    logic [2:0]   apr_fm_block_h;
    logic [3:0]   apr_fm_adr_h;
    logic         con_fm_write_h, fm_check_h, fm_parity_clr_h;
    logic         ctl_ad_to_ebus_h, diag_read_h;
    logic [2:0]   diag_sel_h;
    logic [W-1:0] ar_h, arx_h, br_h, brx_h, mq_h, ad_h, fm_h, ebus_d_h;
    logic         ad_cry_out_h, ad_cg_h, ad_cp_h, ad_eq0_l;
    logic         edp_fm_parity_h, fm_parity_err_h;

    int n_total = 0;
    int n_bad   = 0;
    int n_cyc   = 0;

    // Reference model state
    int m_ar, m_arx, m_br, m_brx, m_mq, m_err;
    int m_fm [ND];
    int m_par [ND];
    int m_valid [ND];
    // Model combinational results for the current inputs
    int e_ad, e_cry, e_cg, e_cp, e_fm, e_fpar, e_ebus;

    edp_slice_param #(.WIDTH(W), .FM_BLOCKS(NB), .FM_ACS(NA)) dut (
        .clk_edp_h(clk_edp_h), .reset_h(reset_h),
        .cache_data_h(cache_data_h), .sh_h(sh_h), .armm_h(armm_h),
        .vma_held_or_pc_h(vma_held_or_pc_h), .ad_cry_in_h(ad_cry_in_h),
        .shift_in_lsb_h(shift_in_lsb_h), .cram_ad_boole_h(cram_ad_boole_h),
        .cram_ad_sel_h(cram_ad_sel_h), .cram_ada_sel_h(cram_ada_sel_h),
        .cram_ada_dis_h(cram_ada_dis_h), .cram_adb_sel_h(cram_adb_sel_h),
        .ctl_arl_sel_h(ctl_arl_sel_h), .ctl_ar_load_h(ctl_ar_load_h),
        .ctl_ar_clr_h(ctl_ar_clr_h), .ctl_arxl_sel_h(ctl_arxl_sel_h),
        .ctl_arx_load_h(ctl_arx_load_h), .cram_br_load_h(cram_br_load_h),
        .cram_brx_load_h(cram_brx_load_h), .ctl_mq_sel_h(ctl_mq_sel_h),
        .ctl_mqm_en_h(ctl_mqm_en_h), .apr_fm_block_h(apr_fm_block_h),
        .apr_fm_adr_h(apr_fm_adr_h), .con_fm_write_h(con_fm_write_h),
        .fm_check_h(fm_check_h), .fm_parity_clr_h(fm_parity_clr_h),
        .ctl_ad_to_ebus_h(ctl_ad_to_ebus_h), .diag_read_h(diag_read_h),
        .diag_sel_h(diag_sel_h),
        .ar_h(ar_h), .arx_h(arx_h), .br_h(br_h), .brx_h(brx_h), .mq_h(mq_h),
        .ad_h(ad_h), .ad_cry_out_h(ad_cry_out_h), .ad_cg_h(ad_cg_h),
        .ad_cp_h(ad_cp_h), .ad_eq0_l(ad_eq0_l), .fm_h(fm_h),
        .ebus_d_h(ebus_d_h), .edp_fm_parity_h(edp_fm_parity_h),
        .fm_parity_err_h(fm_parity_err_h)
    );

    always #5 clk_edp_h = ~clk_edp_h;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input int v);
        int c = 0;
        for (int i = 0; i < W; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int cur_idx();
        return int'(apr_fm_block_h) * NA + int'(apr_fm_adr_h);
    endfunction

    task automatic set_idle();
        cache_data_h = '0; sh_h = '0; armm_h = '0; vma_held_or_pc_h = '0;
        ad_cry_in_h = 0; shift_in_lsb_h = 0; cram_ad_boole_h = 0;
        cram_ad_sel_h = 0; cram_ada_sel_h = 0; cram_ada_dis_h = 0;
        cram_adb_sel_h = 2'd1;
        ctl_arl_sel_h = 0; ctl_ar_load_h = 0; ctl_ar_clr_h = 0;
        ctl_arxl_sel_h = 0; ctl_arx_load_h = 0;
        cram_br_load_h = 0; cram_brx_load_h = 0;
        ctl_mq_sel_h = 0; ctl_mqm_en_h = 0;
        apr_fm_block_h = 0; apr_fm_adr_h = 0;
        con_fm_write_h = 0; fm_check_h = 0; fm_parity_clr_h = 0;
        ctl_ad_to_ebus_h = 0; diag_read_h = 0; diag_sel_h = 0;
    endtask

    task automatic model_reset();
        m_ar = 0; m_arx = 0; m_br = 0; m_brx = 0; m_mq = 0; m_err = 0;
    endtask

    // Adder, FM read and EBUS as plain integer arithmetic on the model state
    task automatic model_comb();
        int a, b, t, s, idx;
        idx    = cur_idx();
        e_fm   = m_fm[idx];
        e_fpar = m_par[idx];
        a = 0;
        if (!cram_ada_dis_h) begin
            case (cram_ada_sel_h)
                0: a = m_ar;
                1: a = m_arx;
                2: a = m_mq;
                default: a = int'(vma_held_or_pc_h);
            endcase
        end
        case (cram_adb_sel_h)
            0: b = e_fm;
            1: b = m_br;
            2: b = m_brx;
            default: b = m_ar;
        endcase
        if (!cram_ad_boole_h) begin
            case (cram_ad_sel_h)
                0: t = b;
                1: t = M - b;
                2: t = a;
                default: t = 0;
            endcase
            s     = a + t + int'(ad_cry_in_h);
            e_ad  = s & M;
            e_cry = (s >> W) & 1;
            e_cg  = ((a + t) >> W) & 1;
            e_cp  = (((a + t + 1) >> W) & 1) ^ e_cg;
        end else begin
            case (cram_ad_sel_h)
                0: e_ad = a & b;
                1: e_ad = a | b;
                2: e_ad = a ^ b;
                default: e_ad = M - a;
            endcase
            e_cry = 0; e_cg = 0; e_cp = 0;
        end
        if (diag_read_h) begin
            case (diag_sel_h)
                0: e_ebus = m_ar;
                1: e_ebus = m_arx;
                2: e_ebus = m_br;
                3: e_ebus = m_brx;
                4: e_ebus = m_mq;
                5: e_ebus = e_fm;
                6: e_ebus = e_ad;
                default: e_ebus = 0;
            endcase
        end else if (ctl_ad_to_ebus_h) begin
            e_ebus = e_ad;
        end else begin
            e_ebus = 0;
        end
    endtask

    // Clock-edge update of the model, using pre-edge values throughout
    task automatic model_edge();
        int n_ar, n_arx, n_br, n_brx, n_mq, idx, set;
        idx = cur_idx();
        n_ar = m_ar; n_arx = m_arx; n_br = m_br; n_brx = m_brx; n_mq = m_mq;
        if (ctl_ar_clr_h) n_ar = 0;
        else if (ctl_ar_load_h) begin
            case (ctl_arl_sel_h)
                0: n_ar = int'(armm_h);
                1: n_ar = int'(cache_data_h);
                2: n_ar = e_ad;
                3: n_ar = int'(sh_h);
                4: n_ar = ((e_ad << 1) | int'(shift_in_lsb_h)) & M;
                5: n_ar = (e_cry << (W - 1)) | (e_ad >> 1);
                6: n_ar = e_fm;
                default: n_ar = 0;
            endcase
        end
        if (ctl_arx_load_h) begin
            case (ctl_arxl_sel_h)
                0: n_arx = int'(cache_data_h);
                1: n_arx = e_ad;
                2: n_arx = m_ar;
                default: n_arx = m_mq;
            endcase
        end
        if (cram_br_load_h)  n_br  = m_ar;
        if (cram_brx_load_h) n_brx = m_arx;
        if (ctl_mqm_en_h) begin
            case (ctl_mq_sel_h)
                1: n_mq = ((m_mq << 1) | int'(shift_in_lsb_h)) & M;
                2: n_mq = ((e_ad & 1) << (W - 1)) | (m_mq >> 1);
                3: n_mq = e_ad;
                default: n_mq = m_mq;
            endcase
        end
        set = (fm_check_h && ((ones(e_fm) + e_fpar) % 2 == 0)) ? 1 : 0;
        m_err = (set != 0 || (m_err != 0 && !fm_parity_clr_h)) ? 1 : 0;
        if (con_fm_write_h) begin
            m_fm[idx]    = m_ar;
            m_par[idx]   = (ones(m_ar) % 2 == 0) ? 1 : 0;
            m_valid[idx] = 1;
        end
        m_ar = n_ar; m_arx = n_arx; m_br = n_br; m_brx = n_brx; m_mq = n_mq;
    endtask

    // One clock: predict, compare between edges, then advance the model
    task automatic cycle();
        int idx;
        model_comb();
        idx = cur_idx();
        @(negedge clk_edp_h);
        check_val("ar", int'(ar_h), m_ar);
        check_val("arx", int'(arx_h), m_arx);
        check_val("br", int'(br_h), m_br);
        check_val("brx", int'(brx_h), m_brx);
        check_val("mq", int'(mq_h), m_mq);
        check_val("ad", int'(ad_h), e_ad);
        check_val("cry", int'(ad_cry_out_h), e_cry);
        check_val("cg", int'(ad_cg_h), e_cg);
        check_val("cp", int'(ad_cp_h), e_cp);
        check_val("eq0_l", int'(ad_eq0_l), (e_ad != 0) ? 1 : 0);
        check_val("ebus", int'(ebus_d_h), e_ebus);
        check_val("perr", int'(fm_parity_err_h), m_err);
        if (m_valid[idx] != 0) begin
            check_val("fm", int'(fm_h), e_fm);
            check_val("fmpar", int'(edp_fm_parity_h), e_fpar);
        end
        $display("cyc=%0d ar=%o arx=%o br=%o mq=%o ad=%o ebus=%o err=%0d",
                 n_cyc, ar_h, arx_h, br_h, mq_h, ad_h, ebus_d_h, fm_parity_err_h);
        n_cyc++;
        @(posedge clk_edp_h);
        model_edge();
        #1;
    endtask

    initial begin
        int sr_exp [4];
        int old_fm;
        sr_exp = '{'o40, 'o60, 'o70, 'o74};
        for (int i = 0; i < ND; i++) begin
            m_fm[i] = 0; m_par[i] = 0; m_valid[i] = 0;
        end
        model_reset();
        set_idle();

        // Reset state
        repeat (2) @(posedge clk_edp_h);
        #1 reset_h = 1'b0;
        check_val("rst_ar", int'(ar_h), 0);
        check_val("rst_arx", int'(arx_h), 0);
        check_val("rst_br", int'(br_h), 0);
        check_val("rst_brx", int'(brx_h), 0);
        check_val("rst_mq", int'(mq_h), 0);
        check_val("rst_err", int'(fm_parity_err_h), 0);
        check_val("rst_ebus", int'(ebus_d_h), 0);

        // Asynchronous reset pulse while AR is loading 77
        armm_h = 6'o77; ctl_ar_load_h = 1;
        cycle();
        check_val("ar77", int'(ar_h), 'o77);
        #1 reset_h = 1'b1;
        #1;
        check_val("arst_ar", int'(ar_h), 0);
        check_val("arst_mq", int'(mq_h), 0);
        check_val("arst_err", int'(fm_parity_err_h), 0);
        check_val("arst_ebus", int'(ebus_d_h), 0);
        model_reset();
        #1 reset_h = 1'b0;
        ctl_ar_load_h = 0;

        // Fill every FM location through AR
        for (int i = 0; i < ND; i++) begin
            armm_h = W'((i * 5 + 3) & M); ctl_ar_load_h = 1; ctl_arl_sel_h = 0;
            cycle();
            ctl_ar_load_h = 0;
            apr_fm_block_h = 3'(i / NA); apr_fm_adr_h = 4'(i % NA); con_fm_write_h = 1;
            cycle();
            con_fm_write_h = 0;
        end
        apr_fm_block_h = 0; apr_fm_adr_h = 0;

        // Adder: 12 + 34 + 1
        armm_h = 6'o34; ctl_ar_load_h = 1; cycle();
        armm_h = 6'o12; cram_br_load_h = 1; cycle();
        ctl_ar_load_h = 0; cram_br_load_h = 0;
        cram_ada_sel_h = 0; cram_adb_sel_h = 1; cram_ad_sel_h = 0; ad_cry_in_h = 1;
        #1;
        check_val("add47", int'(ad_h), 'o47);
        check_val("add47_cry", int'(ad_cry_out_h), 0);
        cycle();
        // Adder: 77 + 01 wraps to zero
        armm_h = 6'o01; ctl_ar_load_h = 1; ad_cry_in_h = 0; cycle();
        armm_h = 6'o77; cram_br_load_h = 1; cycle();
        ctl_ar_load_h = 0; cram_br_load_h = 0;
        #1;
        check_val("add0", int'(ad_h), 0);
        check_val("add0_cry", int'(ad_cry_out_h), 1);
        check_val("add0_eq0", int'(ad_eq0_l), 0);
        check_val("add0_cg", int'(ad_cg_h), 1);
        check_val("add0_cp", int'(ad_cp_h), 0);
        cycle();

        // FM write of 25 to block 3 AC 5 with read-during-write
        armm_h = 6'o25; ctl_ar_load_h = 1; cycle();
        ctl_ar_load_h = 0;
        apr_fm_block_h = 3; apr_fm_adr_h = 5; con_fm_write_h = 1;
        old_fm = m_fm[3 * NA + 5];
        #1;
        check_val("fm_old", int'(fm_h), old_fm);
        cycle();
        con_fm_write_h = 0;
        check_val("fm25", int'(fm_h), 'o25);
        check_val("fm25_par", int'(edp_fm_parity_h), 0);

        // Parity error via stored-bit flip
        dut.fm_mem[3 * NA + 5][W] = ~dut.fm_mem[3 * NA + 5][W];
        m_par[3 * NA + 5] = 1 - m_par[3 * NA + 5];
        fm_check_h = 1;
        #1;
        check_val("perr_pre", int'(fm_parity_err_h), 0);
        cycle();
        check_val("perr_set", int'(fm_parity_err_h), 1);
        fm_check_h = 0; cycle();
        check_val("perr_hold", int'(fm_parity_err_h), 1);
        fm_parity_clr_h = 1; cycle();
        check_val("perr_clr", int'(fm_parity_err_h), 0);
        fm_check_h = 1; cycle();
        check_val("perr_setclr", int'(fm_parity_err_h), 1);
        fm_check_h = 0; cycle();
        check_val("perr_clr2", int'(fm_parity_err_h), 0);
        fm_parity_clr_h = 0;
        dut.fm_mem[3 * NA + 5][W] = ~dut.fm_mem[3 * NA + 5][W];
        m_par[3 * NA + 5] = 1 - m_par[3 * NA + 5];

        // MQ load 01 then shift right with AD LSB = 1
        cram_ada_dis_h = 1; cram_ad_sel_h = 3; ad_cry_in_h = 1;
        ctl_mq_sel_h = 3; ctl_mqm_en_h = 1; cycle();
        check_val("mq01", int'(mq_h), 'o01);
        ctl_mq_sel_h = 2;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_val("mq_sr", int'(mq_h), sr_exp[k]);
        end
        ctl_mqm_en_h = 0; cycle();
        check_val("mq_hold", int'(mq_h), 'o74);
        cram_ada_dis_h = 0; cram_ad_sel_h = 0; ad_cry_in_h = 0; ctl_mq_sel_h = 0;

        // EBUS priority
        diag_read_h = 1; diag_sel_h = 2; ctl_ad_to_ebus_h = 1;
        #1;
        check_val("ebus_br", int'(ebus_d_h), m_br);
        diag_read_h = 0;
        model_comb();
        #1;
        check_val("ebus_ad", int'(ebus_d_h), e_ad);
        ctl_ad_to_ebus_h = 0;
        #1;
        check_val("ebus_zero", int'(ebus_d_h), 0);

        // Randomized cycles
        for (int n = 0; n < 400; n++) begin
            cache_data_h = W'($urandom); sh_h = W'($urandom); armm_h = W'($urandom);
            vma_held_or_pc_h = W'($urandom);
            ad_cry_in_h = 1'($urandom); shift_in_lsb_h = 1'($urandom);
            cram_ad_boole_h = 1'($urandom); cram_ad_sel_h = 2'($urandom);
            cram_ada_sel_h = 2'($urandom); cram_ada_dis_h = ($urandom_range(0, 3) == 0);
            cram_adb_sel_h = 2'($urandom);
            ctl_arl_sel_h = 3'($urandom); ctl_ar_load_h = 1'($urandom);
            ctl_ar_clr_h = ($urandom_range(0, 7) == 0);
            ctl_arxl_sel_h = 2'($urandom); ctl_arx_load_h = 1'($urandom);
            cram_br_load_h = 1'($urandom); cram_brx_load_h = 1'($urandom);
            ctl_mq_sel_h = 2'($urandom); ctl_mqm_en_h = 1'($urandom);
            apr_fm_block_h = 3'($urandom); apr_fm_adr_h = 4'($urandom);
            con_fm_write_h = 1'($urandom); fm_check_h = 1'($urandom);
            fm_parity_clr_h = ($urandom_range(0, 3) == 0);
            ctl_ad_to_ebus_h = 1'($urandom); diag_read_h = 1'($urandom);
            diag_sel_h = 3'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/edp_slice_param.md
Name: edp_slice_param

Overview:
- Parametrised successor to the fixed 6-bit EDP slice: one WIDTH-bit slice of the execution data path.
- Contains the AR/ARX/BR/BRX/MQ registers, the A/B-select adder with lookahead generate/propagate, a fast-memory (FM) array with parity and a sticky parity-error flag, and an EBUS/diagnostic read driver.
- Slices are cascaded via carry and lookahead signals to form the full 36-bit word.

Parameters:
- WIDTH, 6, bits per slice; bit 0 is the most significant bit.
- FM_BLOCKS, 8, number of AC blocks in the fast memory.
- FM_ACS, 16, ACs per block.

Ports:
- clk_edp_h  in  1  slice clock; all state changes on the rising edge.
- reset_h  in  1  asynchronous active-high reset.
- cache_data_h  in  WIDTH  cache data input.
- sh_h  in  WIDTH  shifter output.
- armm_h  in  WIDTH  AR misc-mux input.
- vma_held_or_pc_h  in  WIDTH  VMA/PC input.
- ad_cry_in_h  in  1  carry from the less-significant slice.
- shift_in_lsb_h  in  1  bit shifted into the LSB on a left shift.
- cram_ad_boole_h  in  1  0 selects arithmetic, 1 selects boolean.
- cram_ad_sel_h  in  2  adder function select.
- cram_ada_sel_h  in  2  A-operand select.
- cram_ada_dis_h  in  1  forces A to 0.
- cram_adb_sel_h  in  2  B-operand select.
- ctl_arl_sel_h  in  3  AR source select.
- ctl_ar_load_h  in  1  AR load enable.
- ctl_ar_clr_h  in  1  AR clear.
- ctl_arxl_sel_h  in  2  ARX source select.
- ctl_arx_load_h  in  1  ARX load enable.
- cram_br_load_h  in  1  BR<=AR.
- cram_brx_load_h  in  1  BRX<=ARX.
- ctl_mq_sel_h  in  2  MQ function select.
- ctl_mqm_en_h  in  1  MQ enable.
- apr_fm_block_h  in  $clog2(FM_BLOCKS)  FM block number.
- apr_fm_adr_h  in  $clog2(FM_ACS)  FM AC number.
- con_fm_write_h  in  1  write AR into the addressed FM location.
- fm_check_h  in  1  enable the FM parity check this cycle.
- fm_parity_clr_h  in  1  clear the sticky parity-error flag.
- ctl_ad_to_ebus_h  in  1  drive AD onto the EBUS.
- diag_read_h  in  1  diagnostic read enable.
- diag_sel_h  in  3  diagnostic register select.
- ar_h, arx_h, br_h, brx_h, mq_h  out  WIDTH each  register outputs.
- ad_h  out  WIDTH  adder result.
- ad_cry_out_h  out  1  carry out of bit 0.
- ad_cg_h  out  1  slice carry generate.
- ad_cp_h  out  1  slice carry propagate.
- ad_eq0_l  out  1  low when AD == 0.
- fm_h  out  WIDTH  FM read data.
- ebus_d_h  out  WIDTH  EBUS data.
- edp_fm_parity_h  out  1  stored parity of the addressed FM word.
- fm_parity_err_h  out  1  sticky FM parity error.

Behaviour:
- Reset is asynchronous.
  - AR, ARX, BR, BRX, MQ and fm_parity_err_h go to 0.
  - FM contents are not reset and are undefined until written.
  - All combinational outputs follow from the reset register values.
- A operand select: 0 AR, 1 ARX, 2 MQ, 3 VMA. ada_dis forces A to 0.
- B operand select: 0 FM, 1 BR, 2 BRX, 3 AR.
- Arithmetic functions (boole=0), all mod 2^WIDTH, carry-in ad_cry_in_h:
  - sel 0: A+B+cin.
  - sel 1: A+~B+cin.
  - sel 2: A+A+cin.
  - sel 3: A+cin.
  - ad_cry_out_h is bit WIDTH of the sum.
  - cg = carry-out with cin=0; cp = carry-out with cin=1 XOR cg, i.e. the slice propagates.
- Boolean functions (boole=1): sel 0 A&B, 1 A|B, 2 A^B, 3 ~A. cg=0, cp=0, cry_out=0.
- AR update, taken on a clock edge:
  - ar_clr has priority over ar_load and yields 0.
  - ar_load with arl_sel: 0 ARMM, 1 CACHE, 2 AD, 3 SH, 4 {AD[1:],shift_in_lsb}, 5 {ad_cry_out,AD[0:WIDTH-2]}, 6 FM, 7 zero.
- ARX update on arx_load: 0 CACHE, 1 AD, 2 AR, 3 MQ.
- BR and BRX loads capture the pre-edge AR and ARX values.
- MQ update when mqm_en=1: 0 hold, 1 shift left with shift_in_lsb, 2 shift right with AD[WIDTH-1] into bit 0, 3 load AD. MQ holds when mqm_en=0.
- FM organisation:
  - Array of FM_BLOCKS*FM_ACS words, each WIDTH+1 bits (data plus odd parity).
  - Index = block*FM_ACS + adr.
- FM write: synchronous write of the pre-edge AR with odd parity.
- FM read:
  - Combinational from the current address.
  - A same-cycle write followed by a read of the same address returns the old word; the new word is visible the next cycle.
- Parity error: if fm_check_h=1 and the parity of fm_h XOR the stored bit is 0, fm_parity_err_h sets at the edge and stays set.
  - fm_parity_clr_h clears it.
  - A simultaneous set and clear leaves it set.
- EBUS and diagnostic output:
  - diag_read has priority; sel 0 AR, 1 ARX, 2 BR, 3 BRX, 4 MQ, 5 FM, 6 AD, 7 zero.
  - Otherwise ad_to_ebus drives AD.
  - Otherwise ebus_d_h = 0.
- All outputs are driven combinationally from state, with zero-cycle EBUS latency.

Test Plan:
- Reset pulse mid-cycle while AR loads 6'o77: all registers read 0 immediately, fm_parity_err=0, ebus=0.
- AR=6'o12, BR=6'o34, ada=AR, adb=BR, arith sel0, cin=1: AD=6'o47, cry_out=0. Repeat with AR=6'o77, BR=6'o01, cin=0: AD=0, cry_out=1, ad_eq0_l=0, cg=1.
- Write AR=6'o25 to block 3 AC 5, then read the same address: fm_h=6'o25, edp_fm_parity_h=0 (three ones, so the odd-parity bit is 0). Read in the write cycle returns the old contents.
- Force a stored parity flip via the bench backdoor, then fm_check=1: err sets the next edge, persists, clears on fm_parity_clr.
- MQ=6'o01, shift right four times with AD LSB=1: MQ = 6'o40, 6'o60, 6'o70, 6'o74. mqm_en=0 holds.
- diag_read=1 with sel=2 and ad_to_ebus=1: ebus=BR; drop diag_read: ebus=AD; drop both: ebus=0.
